// File: rtl/bicubic_pkg.sv
// Shared types and constants for the bicubic tap sequencer and its helpers.
package bicubic_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned CODE_W       = 3;
  localparam int unsigned TAPS         = 4;
  localparam int unsigned TABLE_PHASES = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Weight codes understood by bicubic_vector_mult. Values are in units of
  // 2^-7 and every table row sums to 128 (UNITY).
  typedef enum logic [CODE_W-1:0] {
    WC_ZERO   = 3'd0,   //    0
    WC_UNITY  = 3'd1,   //  128
    WC_NEG9   = 3'd2,   //   -9
    WC_POS111 = 3'd3,   //  111
    WC_POS29  = 3'd4,   //   29
    WC_NEG3   = 3'd5,   //   -3
    WC_NEG8   = 3'd6,   //   -8
    WC_POS72  = 3'd7    //   72
  } weight_code_t;

  typedef logic [0:TAPS-1][CODE_W-1:0] tap_codes_t;

  // Catmull-Rom (a=-0.5) weights at t = 0, 1/4, 1/2, 3/4 for taps w0..w3.
  localparam tap_codes_t PHASE_WEIGHT [TABLE_PHASES] = '{
    '{WC_ZERO,  WC_UNITY,  WC_ZERO,   WC_ZERO},
    '{WC_NEG9,  WC_POS111, WC_POS29,  WC_NEG3},
    '{WC_NEG8,  WC_POS72,  WC_POS72,  WC_NEG8},
    '{WC_NEG3,  WC_POS29,  WC_POS111, WC_NEG9}
  };

  // Maps an output phase onto the nearest lower table row for any
  // power-of-two phase count.
  function automatic tap_codes_t phase_codes(input int unsigned phase,
                                             input int unsigned phases);
    logic [1:0] idx;
    idx = 2'((phase * TABLE_PHASES) / phases);
    return PHASE_WEIGHT[idx];
  endfunction

  // Signed weight a code stands for, as the external multiplier decodes it.
  function automatic int code_weight(input logic [CODE_W-1:0] code);
    case (code)
      3'd0:    return 0;
      3'd1:    return 128;
      3'd2:    return -9;
      3'd3:    return 111;
      3'd4:    return 29;
      3'd5:    return -3;
      3'd6:    return -8;
      default: return 72;
    endcase
  endfunction

endpackage

// File: rtl/bicubic_round_clamp.sv
// Rounds a signed fixed-point inner product to the nearest integer and
// saturates it into the unsigned 8-bit pixel range.
module bicubic_round_clamp
  import bicubic_pkg::*;
#(
  parameter int unsigned IPW       = 24,
  parameter int unsigned FRAC_BITS = 7
) (
  input  logic signed [IPW-1:0]   ip,
  output logic        [PIX_W-1:0] pix
);

  localparam logic signed [IPW:0] BIAS    = (IPW+1)'(1) << (FRAC_BITS - 1);
  localparam logic signed [IPW:0] MAX_PIX = (IPW+1)'(255);

  logic signed [IPW:0] biased;
  logic signed [IPW:0] rounded;

  // Add half an LSB, floor-shift, then saturate to 0..255.
  always_comb begin
    biased  = $signed({ip[IPW-1], ip}) + BIAS;
    rounded = biased >>> FRAC_BITS;
    pix     = '0;
    if (rounded[IPW]) begin
      pix = '0;
    end else if (rounded > MAX_PIX) begin
      pix = '1;
    end else begin
      pix = rounded[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/bicubic_tap_sequencer.sv
// Streaming 1-D bicubic upscaler: buffers a 4-tap window, sequences phases
// through the external multiplier and registers the rounded result.
module bicubic_tap_sequencer
  import bicubic_pkg::*;
#(
  parameter int unsigned INTER_PRODUCT_WIDTH = 24,
  parameter int unsigned PHASES              = 4,
  parameter int unsigned FRAC_BITS           = 7,
  parameter int unsigned MAX_LINE            = 4096
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [PIX_W-1:0]                      s_pixel,
  input  logic                                  s_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [PIX_W-1:0]                      m_pixel,
  output logic                                  m_last,
  output logic [PIX_W:0]                        mult_pixel_1,
  output logic [PIX_W:0]                        mult_pixel_2,
  output logic [PIX_W:0]                        mult_pixel_3,
  output logic [PIX_W:0]                        mult_pixel_4,
  output logic [CODE_W-1:0]                     mult_weight_1,
  output logic [CODE_W-1:0]                     mult_weight_2,
  output logic [CODE_W-1:0]                     mult_weight_3,
  output logic [CODE_W-1:0]                     mult_weight_4,
  input  logic signed [INTER_PRODUCT_WIDTH-1:0] mult_inner_product
);

  localparam int unsigned PH_W  = $clog2(PHASES);
  localparam int unsigned CNT_W = $clog2(MAX_LINE + 1);

  state_t                    state_q, state_nx;
  logic [1:0]                fill_q, fill_nx;
  logic [PH_W-1:0]           phase_q, phase_nx;
  logic [CNT_W-1:0]          n_in_q, n_in_nx;
  logic [CNT_W-1:0]          groups_q, groups_nx;
  logic [0:TAPS-1][PIX_W-1:0] w_q, w_nx;
  logic                      adv, issue, last_nx, last_phase;
  logic [PIX_W-1:0]          rc_pix;
  tap_codes_t                codes;

  assign adv        = !m_valid || m_ready;
  assign last_phase = (phase_q == PH_W'(PHASES - 1));
  assign codes      = phase_codes(32'(phase_q), PHASES);

  assign mult_pixel_1  = {1'b0, w_q[0]};
  assign mult_pixel_2  = {1'b0, w_q[1]};
  assign mult_pixel_3  = {1'b0, w_q[2]};
  assign mult_pixel_4  = {1'b0, w_q[3]};
  assign mult_weight_1 = codes[0];
  assign mult_weight_2 = codes[1];
  assign mult_weight_3 = codes[2];
  assign mult_weight_4 = codes[3];

  bicubic_round_clamp #(
    .IPW       (INTER_PRODUCT_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_clamp (
    .ip  (mult_inner_product),
    .pix (rc_pix)
  );

  // Next-state, window/counter updates, input ready and issue decision.
  always_comb begin
    state_nx  = state_q;
    fill_nx   = fill_q;
    phase_nx  = phase_q;
    n_in_nx   = n_in_q;
    groups_nx = groups_q;
    w_nx      = w_q;
    s_ready   = 1'b0;
    issue     = 1'b0;
    last_nx   = 1'b0;
    case (state_q)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          n_in_nx = n_in_q + CNT_W'(1);
          fill_nx = fill_q + 2'd1;
          case (fill_q)
            2'd0:    w_nx = {4{s_pixel}};
            2'd1:    w_nx = {w_q[0], w_q[0], s_pixel, s_pixel};
            default: w_nx = {w_q[0], w_q[1], w_q[2], s_pixel};
          endcase
          if (s_last) begin
            state_nx  = FLUSH;
            fill_nx   = '0;
            phase_nx  = '0;
            groups_nx = '0;
          end else if (fill_q == 2'd2) begin
            state_nx = RUN;
            fill_nx  = '0;
          end
        end
      end
      RUN: begin
        if (!last_phase) begin
          if (adv) begin
            issue    = 1'b1;
            phase_nx = phase_q + PH_W'(1);
          end
        end else begin
          // The last phase of a group only fires together with the pixel
          // that slides the window, so issue/shift/phase reset are atomic.
          s_ready = adv;
          if (s_valid && adv) begin
            issue     = 1'b1;
            phase_nx  = '0;
            w_nx      = {w_q[1], w_q[2], w_q[3], s_pixel};
            groups_nx = groups_q + CNT_W'(1);
            n_in_nx   = n_in_q + CNT_W'(1);
            if (s_last) state_nx = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          issue = 1'b1;
          if (!last_phase) begin
            phase_nx = phase_q + PH_W'(1);
          end else begin
            phase_nx  = '0;
            groups_nx = groups_q + CNT_W'(1);
            if (groups_q + CNT_W'(1) == n_in_q) begin
              last_nx   = 1'b1;
              state_nx  = FILL;
              n_in_nx   = '0;
              groups_nx = '0;
            end else begin
              w_nx = {w_q[1], w_q[2], w_q[3], w_q[3]};
            end
          end
        end
      end
      default: state_nx = FILL;
    endcase
  end

  // State, window, counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      fill_q   <= '0;
      phase_q  <= '0;
      n_in_q   <= '0;
      groups_q <= '0;
      w_q      <= '0;
      m_valid  <= 1'b0;
      m_pixel  <= '0;
      m_last   <= 1'b0;
    end else begin
      state_q  <= state_nx;
      fill_q   <= fill_nx;
      phase_q  <= phase_nx;
      n_in_q   <= n_in_nx;
      groups_q <= groups_nx;
      w_q      <= w_nx;
      if (adv) m_valid <= issue;
      if (issue) begin
        m_pixel <= rc_pix;
        m_last  <= last_nx;
      end
    end
  end

endmodule
